// File: rtl/rr_grant_reg.sv
// rr_grant_reg: round-robin arbiter with a registered grant.
// A winner is chosen from reqs_i starting at a rotating priority pointer and
// held in flops until the consumer accepts it with yumi_i. On acceptance the
// pointer moves just past the accepted requester, and a new winner is loaded
// in the same cycle if any request is present.
//
// Ports:
//   clk_i      : clock, all state updates on the rising edge
//   reset_n_i  : asynchronous active-low reset
//   reqs_i     : request vector, bit k = requester k wants service
//   yumi_i     : consumer accepts the current grant (ignored when v_o=0)
//   v_o        : registered grant valid
//   grant_o    : registered one-hot grant, zero when v_o=0
//   tag_o      : registered binary index of grant_o, zero when v_o=0
module rr_grant_reg #(
  parameter int width_p     = 4,
  parameter int tag_width_p = (width_p > 1) ? $clog2(width_p) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [width_p-1:0]     reqs_i,
  input  logic                   yumi_i,
  output logic                   v_o,
  output logic [width_p-1:0]     grant_o,
  output logic [tag_width_p-1:0] tag_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e                 r_state;
  logic                   r_armed;
  logic [tag_width_p-1:0] r_ptr;
  logic                   r_v;
  logic [width_p-1:0]     r_grant;
  logic [tag_width_p-1:0] r_tag;

  logic                   w_accept;
  logic [tag_width_p-1:0] w_ptr_inc;
  logic [tag_width_p-1:0] w_ptr_sel;
  logic [width_p-1:0]     w_masked;
  logic [width_p-1:0]     w_scan_m;
  logic [width_p-1:0]     w_scan_u;
  logic [width_p-1:0]     w_oh_m;
  logic [width_p-1:0]     w_oh_u;
  logic [width_p-1:0]     w_win;
  logic [tag_width_p-1:0] w_win_tag;

  assign w_accept  = (r_state == GRANT) && yumi_i;
  assign w_ptr_inc = (r_tag == tag_width_p'(width_p - 1)) ? '0
                                                          : r_tag + tag_width_p'(1);
  // A back-to-back winner must already see the pointer moved past the
  // requester being accepted, so select with the incremented value.
  assign w_ptr_sel = w_accept ? w_ptr_inc : r_ptr;

  always_comb begin
    w_masked  = '0;
    w_scan_m  = '0;
    w_scan_u  = '0;
    w_oh_m    = '0;
    w_oh_u    = '0;
    w_win     = '0;
    w_win_tag = '0;

    for (int unsigned k = 0; k < width_p; k++) begin
      w_masked[k] = reqs_i[k] && (k >= 32'(w_ptr_sel));
    end

    // Lo-to-hi OR scans; the first set bit of each scan is the winner.
    w_scan_m[0] = w_masked[0];
    w_scan_u[0] = reqs_i[0];
    for (int unsigned k = 1; k < width_p; k++) begin
      w_scan_m[k] = w_scan_m[k-1] | w_masked[k];
      w_scan_u[k] = w_scan_u[k-1] | reqs_i[k];
    end

    w_oh_m[0] = w_scan_m[0];
    w_oh_u[0] = w_scan_u[0];
    for (int unsigned k = 1; k < width_p; k++) begin
      w_oh_m[k] = w_scan_m[k] & ~w_scan_m[k-1];
      w_oh_u[k] = w_scan_u[k] & ~w_scan_u[k-1];
    end

    // Nothing at/above the pointer: wrap to the lowest request overall.
    w_win = (|w_masked) ? w_oh_m : w_oh_u;

    for (int unsigned k = 0; k < width_p; k++) begin
      if (w_win[k]) begin
        w_win_tag = w_win_tag | tag_width_p'(k);
      end
    end
  end

  // r_armed holds off the first grant for one edge after reset release, so a
  // grant never appears before the second rising edge after deassertion.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
      r_armed <= 1'b0;
      r_ptr   <= '0;
      r_v     <= 1'b0;
      r_grant <= '0;
      r_tag   <= '0;
    end else if (!r_armed) begin
      r_armed <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (|reqs_i) begin
            r_state <= GRANT;
            r_v     <= 1'b1;
            r_grant <= w_win;
            r_tag   <= w_win_tag;
          end
        end
        GRANT: begin
          if (yumi_i) begin
            r_ptr <= w_ptr_inc;
            if (|reqs_i) begin
              r_grant <= w_win;
              r_tag   <= w_win_tag;
            end else begin
              r_state <= IDLE;
              r_v     <= 1'b0;
              r_grant <= '0;
              r_tag   <= '0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_v     <= 1'b0;
          r_grant <= '0;
          r_tag   <= '0;
        end
      endcase
    end
  end

  assign v_o     = r_v;
  assign grant_o = r_grant;
  assign tag_o   = r_tag;

endmodule

// File: tb/tb_rr_grant_reg.sv
module tb_rr_grant_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [3:0] reqs4;
  logic       yumi4;
  logic       v4;
  logic [3:0] grant4;
  logic [1:0] tag4;

  logic [2:0] reqs3;
  logic       yumi3;
  logic       v3;
  logic [2:0] grant3;
  logic [1:0] tag3;

  logic [0:0] reqs1;
  logic       yumi1;
  logic       v1;
  logic [0:0] grant1;
  logic [0:0] tag1;

  rr_grant_reg #(.width_p(4)) u_dut4 (
    .clk_i(clk), .reset_n_i(rst_n), .reqs_i(reqs4), .yumi_i(yumi4),
    .v_o(v4), .grant_o(grant4), .tag_o(tag4));

  rr_grant_reg #(.width_p(3)) u_dut3 (
    .clk_i(clk), .reset_n_i(rst_n), .reqs_i(reqs3), .yumi_i(yumi3),
    .v_o(v3), .grant_o(grant3), .tag_o(tag3));

  rr_grant_reg #(.width_p(1)) u_dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .reqs_i(reqs1), .yumi_i(yumi1),
    .v_o(v1), .grant_o(grant1), .tag_o(tag1));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model for the width-4 instance: pointer, valid, granted index.
  int m_v, m_g, m_ptr, m_arm;
  bit m_evt;

  function automatic int winner(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = (p + i) % 4;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_v = 0; m_g = 0; m_ptr = 0; m_arm = 0; m_evt = 0;
  endtask

  // Apply inputs, advance the model by one edge, wait past the edge.
  task automatic tick(input logic [3:0] r, input logic y);
    reqs4 = r;
    yumi4 = y;
    m_evt = 0;
    if (m_arm == 0) begin
      m_arm = 1;
    end else if (m_v == 0) begin
      if (r != 4'b0) begin
        m_g = winner(r, m_ptr); m_v = 1; m_evt = 1;
      end
    end else if (y) begin
      m_ptr = (m_g + 1) % 4;
      if (r != 4'b0) begin
        m_g = winner(r, m_ptr); m_evt = 1;
      end else begin
        m_v = 0; m_g = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    n_cmp++;
    if ({v4, grant4, tag4} !== 7'b0 || {v3, grant3, tag3} !== 6'b0 || {v1, grant1, tag1} !== 3'b0) begin
      n_bad++;
      $display("FAIL reset_state: got v4/g4/t4=%b v3/g3/t3=%b v1/g1/t1=%b, want all zero",
               {v4, grant4, tag4}, {v3, grant3, tag3}, {v1, grant1, tag1});
    end
    rst_n = 1'b1;
    model_reset();
    tick(4'b0101, 1'b0);
    n_cmp++;
    if ({v4, grant4, tag4} !== 7'b0) begin
      n_bad++;
      $display("FAIL first_edge_after_reset: got %b, want 0000000", {v4, grant4, tag4});
    end
    tick(4'b0101, 1'b0);
    n_cmp++;
    if ({v4, grant4, tag4} !== {1'b1, 4'b0001, 2'd0}) begin
      n_bad++;
      $display("FAIL first_grant: got v=%b g=%b t=%0d, want v=1 g=0001 t=0", v4, grant4, tag4);
    end
  endtask

  task automatic test_back_to_back();
    tick(4'b0101, 1'b1);
    n_cmp++;
    if ({v4, grant4, tag4} !== {1'b1, 4'b0100, 2'd2}) begin
      n_bad++;
      $display("FAIL back_to_back: got v=%b g=%b t=%0d, want v=1 g=0100 t=2", v4, grant4, tag4);
    end
    tick(4'b0000, 1'b1);
    n_cmp++;
    if ({v4, grant4, tag4} !== 7'b0) begin
      n_bad++;
      $display("FAIL drain_to_idle: got v=%b g=%b t=%0d, want all zero", v4, grant4, tag4);
    end
  endtask

  task automatic test_wrap();
    // pointer is 3 here
    tick(4'b0011, 1'b0);
    n_cmp++;
    if ({v4, grant4, tag4} !== {1'b1, 4'b0001, 2'd0}) begin
      n_bad++;
      $display("FAIL wrap_grant: got v=%b g=%b t=%0d, want v=1 g=0001 t=0", v4, grant4, tag4);
    end
    tick(4'b0000, 1'b1);
    tick(4'b0011, 1'b0);
    n_cmp++;
    if ({v4, grant4, tag4} !== {1'b1, 4'b0010, 2'd1}) begin
      n_bad++;
      $display("FAIL wrap_ptr_is_1: got v=%b g=%b t=%0d, want v=1 g=0010 t=1", v4, grant4, tag4);
    end
    tick(4'b0000, 1'b1);
  endtask

  task automatic test_hold();
    // pointer is 2 here; only requester 1 asks, so selection wraps to it
    tick(4'b0010, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(4'b0000, 1'b0);
      n_cmp++;
      if ({v4, grant4, tag4} !== {1'b1, 4'b0010, 2'd1}) begin
        n_bad++;
        $display("FAIL hold_cycle%0d: got v=%b g=%b t=%0d, want v=1 g=0010 t=1", i, v4, grant4, tag4);
      end
    end
    tick(4'b0000, 1'b1);
    n_cmp++;
    if ({v4, grant4, tag4} !== 7'b0) begin
      n_bad++;
      $display("FAIL hold_release: got v=%b g=%b t=%0d, want all zero", v4, grant4, tag4);
    end
    tick(4'b0110, 1'b0);
    n_cmp++;
    if ({v4, grant4, tag4} !== {1'b1, 4'b0100, 2'd2}) begin
      n_bad++;
      $display("FAIL hold_ptr_is_2: got v=%b g=%b t=%0d, want v=1 g=0100 t=2", v4, grant4, tag4);
    end
    tick(4'b0000, 1'b1);
  endtask

  task automatic test_sole_requester();
    // pointer is 3 here
    tick(4'b0100, 1'b0);
    tick(4'b0100, 1'b1);
    n_cmp++;
    if ({v4, grant4, tag4} !== {1'b1, 4'b0100, 2'd2}) begin
      n_bad++;
      $display("FAIL sole_regrant: got v=%b g=%b t=%0d, want v=1 g=0100 t=2", v4, grant4, tag4);
    end
    tick(4'b0101, 1'b1);
    n_cmp++;
    if ({v4, grant4, tag4} !== {1'b1, 4'b0001, 2'd0}) begin
      n_bad++;
      $display("FAIL granted_lowest_prio: got v=%b g=%b t=%0d, want v=1 g=0001 t=0", v4, grant4, tag4);
    end
    tick(4'b0000, 1'b1);
  endtask

  task automatic test_async_reset();
    tick(4'b1000, 1'b0);
    n_cmp++;
    if ({v4, grant4, tag4} !== {1'b1, 4'b1000, 2'd3}) begin
      n_bad++;
      $display("FAIL pre_reset_grant: got v=%b g=%b t=%0d, want v=1 g=1000 t=3", v4, grant4, tag4);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({v4, grant4, tag4} !== 7'b0) begin
      n_bad++;
      $display("FAIL async_reset_clear: got v=%b g=%b t=%0d, want all zero", v4, grant4, tag4);
    end
    #1 rst_n = 1'b1;
    tick(4'b1000, 1'b0);
    n_cmp++;
    if (v4 !== 1'b0) begin
      n_bad++;
      $display("FAIL release_first_edge: got v=%b, want v=0", v4);
    end
    tick(4'b1000, 1'b0);
    n_cmp++;
    if ({v4, grant4, tag4} !== {1'b1, 4'b1000, 2'd3}) begin
      n_bad++;
      $display("FAIL post_reset_grant: got v=%b g=%b t=%0d, want v=1 g=1000 t=3", v4, grant4, tag4);
    end
    tick(4'b0000, 1'b1);
    yumi4 = 1'b0;
  endtask

  task automatic test_fair3();
    logic [2:0] exp3 [5];
    exp3 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    reqs3 = 3'b111;
    yumi3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [2:0] e;
      logic [1:0] et;
      e  = exp3[i];
      et = (i % 3 == 0) ? 2'd0 : (i % 3 == 1) ? 2'd1 : 2'd2;
      @(posedge clk); #1;
      n_cmp++;
      if ({v3, grant3, tag3} !== {1'b1, e, et}) begin
        n_bad++;
        $display("FAIL fair3_step%0d: got v=%b g=%b t=%0d, want v=1 g=%b t=%0d", i, v3, grant3, tag3, e, et);
      end
    end
    reqs3 = 3'b000;
    @(posedge clk); #1;
    n_cmp++;
    if ({v3, grant3, tag3} !== 6'b0) begin
      n_bad++;
      $display("FAIL fair3_idle: got v=%b g=%b t=%0d, want all zero", v3, grant3, tag3);
    end
    yumi3 = 1'b0;
  endtask

  task automatic test_width1();
    reqs1 = 1'b1;
    yumi1 = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({v1, grant1, tag1} !== 3'b110) begin
      n_bad++;
      $display("FAIL w1_grant: got v=%b g=%b t=%b, want v=1 g=1 t=0", v1, grant1, tag1);
    end
    yumi1 = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({v1, grant1, tag1} !== 3'b110) begin
      n_bad++;
      $display("FAIL w1_regrant: got v=%b g=%b t=%b, want v=1 g=1 t=0", v1, grant1, tag1);
    end
    reqs1 = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({v1, grant1, tag1} !== 3'b000) begin
      n_bad++;
      $display("FAIL w1_idle: got v=%b g=%b t=%b, want all zero", v1, grant1, tag1);
    end
    yumi1 = 1'b0;
  endtask

  task automatic test_random();
    int  cnt [4][4];
    bit  cont [4];
    for (int j = 0; j < 4; j++) begin
      cont[j] = 0;
      for (int k = 0; k < 4; k++) cnt[j][k] = 0;
    end
    rst_n = 1'b0;
    model_reset();
    #2 rst_n = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      logic [3:0] r;
      logic       y;
      logic [3:0] eg;
      logic [1:0] et;
      r = 4'($urandom);
      if ($urandom_range(0, 7) == 0) r = 4'b0;
      y = 1'($urandom_range(0, 1));
      tick(r, y);
      eg = (m_v != 0) ? 4'(32'd1 << m_g) : 4'b0;
      et = (m_v != 0) ? 2'(m_g) : 2'd0;
      n_cmp++;
      if ({v4, grant4, tag4} !== {(m_v != 0), eg, et}) begin
        n_bad++;
        $display("FAIL rand_model c=%0d: got v=%b g=%b t=%0d, want v=%0d g=%b t=%0d", c, v4, grant4, tag4, m_v, eg, et);
      end
      n_cmp++;
      if (v4 ? (!$onehot(grant4) || grant4 !== 4'(32'd1 << tag4)) : (grant4 !== 4'b0 || tag4 !== 2'd0)) begin
        n_bad++;
        $display("FAIL rand_onehot_tag c=%0d: got v=%b g=%b t=%0d, want one-hot matching tag", c, v4, grant4, tag4);
      end
      for (int j = 0; j < 4; j++) if (!r[j]) cont[j] = 0;
      if (m_evt) begin
        int j;
        j = m_g;
        if (cont[j]) begin
          int worst;
          worst = 0;
          for (int k = 0; k < 4; k++) if (k != j && cnt[j][k] > worst) worst = cnt[j][k];
          n_cmp++;
          if (worst > 1) begin
            n_bad++;
            $display("FAIL rand_fairness c=%0d: requester %0d saw another granted %0d times, want at most 1", c, j, worst);
          end
        end
        for (int jj = 0; jj < 4; jj++) if (jj != j) cnt[jj][j]++;
        for (int k = 0; k < 4; k++) cnt[j][k] = 0;
        cont[j] = 1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    reqs4 = '0; yumi4 = 1'b0;
    reqs3 = '0; yumi3 = 1'b0;
    reqs1 = '0; yumi1 = 1'b0;
    test_reset();
    test_back_to_back();
    test_wrap();
    test_hold();
    test_sole_requester();
    test_async_reset();
    test_fair3();
    test_width1();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
